// File: rtl/conv_weight_loader.sv
// Loads one conv kernel (K*K weights + bias) from weight memory into a shadow bank and promotes it to the active outputs on swap.
// Reads take N cycles after the request; load_done follows 2 cycles after the last read; the active set changes only on a swap from READY.
module conv_weight_loader #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_KERNELS = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int IDX_WIDTH   = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      load_req,
  input  logic [IDX_WIDTH-1:0]                      load_kernel_idx,
  output logic                                      load_busy,
  output logic                                      load_done,
  output logic                                      load_err,
  input  logic                                      swap,
  output logic                                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                     mem_addr,
  input  logic [DATA_WIDTH-1:0]                     mem_rd_data,
  output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] weights_out,
  output logic [DATA_WIDTH-1:0]                     bias_out,
  output logic                                      weights_valid
);

  localparam int K2 = KERNEL_SIZE * KERNEL_SIZE;
  localparam int N  = K2 + 1;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0]         LAST = CW'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] N_A  = ADDR_WIDTH'(N);
  localparam logic [IDX_WIDTH:0]    NK   = (IDX_WIDTH + 1)'(NUM_KERNELS);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_READY} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_accept;
  logic                    w_reject;
  logic                    w_last_cap;
  logic                    w_promote;
  logic                    w_idx_ok;
  logic [ADDR_WIDTH-1:0]   w_base;

  logic                    r_rd_en;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [CW-1:0]           r_issue;
  logic                    r_cap_vld;
  logic [CW-1:0]           r_cap_idx;
  logic                    r_done;
  logic                    r_err;

  logic [DATA_WIDTH-1:0]   r_shadow [N];
  logic [DATA_WIDTH*K2-1:0] r_weights;
  logic [DATA_WIDTH-1:0]   r_bias;
  logic                    r_wvalid;

  assign w_idx_ok = ({1'b0, load_kernel_idx} < NK);
  assign w_base   = ADDR_WIDTH'(load_kernel_idx) * N_A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_reject   = 1'b0;
    w_last_cap = 1'b0;
    w_promote  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_req) begin
          if (w_idx_ok) begin
            w_accept = 1'b1;
            w_next   = S_READ;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_READ: begin
        if (r_cap_vld && (r_cap_idx == LAST)) begin
          w_last_cap = 1'b1;
          w_next     = S_READY;
        end
      end
      S_READY: begin
        // A request coinciding with swap is dropped; it is only honoured from IDLE.
        if (swap) begin
          w_promote = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Issue side walks base..base+N-1; capture side trails it by the 1-cycle memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_issue   <= '0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done    <= w_last_cap;
      r_err     <= w_reject;
      r_cap_vld <= r_rd_en;
      r_cap_idx <= r_issue;
      if (w_accept) begin
        r_rd_en <= 1'b1;
        r_addr  <= w_base;
        r_issue <= '0;
      end else if (r_rd_en) begin
        if (r_issue == LAST) begin
          r_rd_en <= 1'b0;
        end else begin
          r_issue <= r_issue + CW'(1);
          r_addr  <= r_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        r_shadow[j] <= '0;
      end
    end else if (r_cap_vld) begin
      for (int j = 0; j < N; j++) begin
        if (r_cap_idx == CW'(j)) begin
          r_shadow[j] <= mem_rd_data;
        end
      end
    end
  end

  // Weight 0 lands in the MSB slot, matching the engine's existing layout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weights <= '0;
      r_bias    <= '0;
      r_wvalid  <= 1'b0;
    end else if (w_promote) begin
      for (int j = 0; j < K2; j++) begin
        r_weights[(K2-1-j)*DATA_WIDTH +: DATA_WIDTH] <= r_shadow[j];
      end
      r_bias   <= r_shadow[N-1];
      r_wvalid <= 1'b1;
    end
  end

  assign load_busy     = (r_state != S_IDLE);
  assign load_done     = r_done;
  assign load_err      = r_err;
  assign mem_rd_en     = r_rd_en;
  assign mem_addr      = r_addr;
  assign weights_out   = r_weights;
  assign bias_out      = r_bias;
  assign weights_valid = r_wvalid;

endmodule

// File: tb/tb_conv_weight_loader.sv
// Directed bench for conv_weight_loader; memory word at address a holds 16'h0100+a.
module tb_conv_weight_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         load_req = 1'b0;
  logic [2:0]   load_kernel_idx = 3'd0;
  logic         swap = 1'b0;
  logic         load_busy;
  logic         load_done;
  logic         load_err;
  logic         mem_rd_en;
  logic [7:0]   mem_addr;
  logic [15:0]  mem_rd_data = 16'h0000;
  logic [143:0] weights_out;
  logic [15:0]  bias_out;
  logic         weights_valid;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  bit busy_seen;
  bit addr_ok;
  bit seen;
  bit changed;

  conv_weight_loader #(
    .KERNEL_SIZE(3), .DATA_WIDTH(16), .NUM_KERNELS(4), .ADDR_WIDTH(8), .IDX_WIDTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_kernel_idx(load_kernel_idx),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err), .swap(swap),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .weights_out(weights_out), .bias_out(bias_out), .weights_valid(weights_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 16'h0100 + {8'h00, mem_addr};
  end

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_rd_en) rd_cnt++;
  endtask

  task automatic load_and_swap(input logic [2:0] idx);
    load_req = 1'b1;
    load_kernel_idx = idx;
    tick();
    load_req = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (load_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("load_done_seen", seen, 1);
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_weights", weights_out, 0);
    check("rst_bias", bias_out, 0);
    check("rst_valid", weights_valid, 0);
    check("rst_busy", load_busy, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);

    rst_n = 1'b1;
    rd_cnt = 0;
    busy_seen = 1'b0;
    repeat (20) begin
      tick();
      if (load_busy) busy_seen = 1'b1;
    end
    check("idle_no_reads", rd_cnt, 0);
    check("idle_not_busy", busy_seen, 0);

    swap = 1'b1;
    tick();
    swap = 1'b0;
    tick();
    check("swap_idle_valid", weights_valid, 0);

    rd_cnt = 0;
    load_req = 1'b1;
    load_kernel_idx = 3'd4;
    tick();
    load_req = 1'b0;
    check("err_pulse", load_err, 1);
    check("err_not_busy", load_busy, 0);
    tick();
    check("err_one_cycle", load_err, 0);
    repeat (5) tick();
    check("err_no_reads", rd_cnt, 0);

    // Basic load of kernel 2, with a stray load_req and swap while reading.
    rd_cnt = 0;
    load_req = 1'b1;
    load_kernel_idx = 3'd2;
    check("pre_load_rd_en", mem_rd_en, 0);
    tick();
    load_req = 1'b0;
    addr_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(mem_rd_en === 1'b1 && mem_addr === 8'(20 + i))) addr_ok = 1'b0;
      if (i == 2) begin
        load_req = 1'b1;
        load_kernel_idx = 3'd1;
      end
      if (i == 3) load_req = 1'b0;
      if (i == 4) swap = 1'b1;
      if (i == 5) swap = 1'b0;
      tick();
    end
    check("addr_seq", addr_ok, 1);
    check("read_count", rd_cnt, 10);
    check("rd_en_off", mem_rd_en, 0);
    check("addr_hold", mem_addr, 29);
    check("done_not_early", load_done, 0);
    check("swap_read_ignored", weights_valid, 0);
    tick();
    check("done_T12", load_done, 1);
    check("busy_ready", load_busy, 1);
    tick();
    check("done_pulse_end", load_done, 0);
    check("ready_no_promote", weights_out, 0);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check("k2_msb", weights_out[143:128], 16'h0114);
    check("k2_lsb", weights_out[15:0], 16'h011C);
    check("k2_bias", bias_out, 16'h011D);
    check("k2_valid", weights_valid, 1);
    check("k2_idle", load_busy, 0);
    check("no_extra_reads", rd_cnt, 10);

    // Double buffering: kernel 0 active while kernel 3 loads.
    load_and_swap(3'd0);
    check("k0_msb", weights_out[143:128], 16'h0100);
    check("k0_bias", bias_out, 16'h0109);
    load_req = 1'b1;
    load_kernel_idx = 3'd3;
    tick();
    load_req = 1'b0;
    seen = 1'b0;
    changed = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (weights_out[143:128] !== 16'h0100) changed = 1'b1;
      if (load_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("k3_done_seen", seen, 1);
    check("active_stable_load", changed, 0);
    repeat (3) tick();
    check("active_stable_ready", weights_out[143:128], 16'h0100);
    check("bias_stable_ready", bias_out, 16'h0109);

    // Swap and load_req together: promotion wins, request dropped, retried next cycle.
    swap = 1'b1;
    load_req = 1'b1;
    load_kernel_idx = 3'd1;
    tick();
    swap = 1'b0;
    check("k3_msb", weights_out[143:128], 16'h011E);
    check("k3_bias", bias_out, 16'h0127);
    check("simul_no_read", mem_rd_en, 0);
    check("simul_idle", load_busy, 0);
    tick();
    load_req = 1'b0;
    check("retry_rd_en", mem_rd_en, 1);
    check("retry_addr", mem_addr, 10);

    // Reset in the 5th read cycle.
    repeat (4) tick();
    check("fifth_read_en", mem_rd_en, 1);
    check("fifth_read_addr", mem_addr, 14);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_en", mem_rd_en, 0);
    check("midrst_valid", weights_valid, 0);
    check("midrst_bias", bias_out, 0);
    check("midrst_weights", weights_out, 0);
    check("midrst_busy", load_busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load_and_swap(3'd3);
    check("post_msb", weights_out[143:128], 16'h011E);
    check("post_lsb", weights_out[15:0], 16'h0126);
    check("post_bias", bias_out, 16'h0127);
    check("post_valid", weights_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_weight_loader.md
Name: conv_weight_loader

Overview:
- Sequences loading of one conv kernel (KERNEL_SIZE² weights plus one bias) from a shared synchronous weight memory into a shadow register bank.
- Presents the packed Weights/Bias buses to the convolution engine in the same layout the engine already consumes.
- Double-buffered: the engine keeps using the active set while the next kernel loads. The shadow set is promoted only on a swap request at a frame boundary.

Parameters:
- KERNEL_SIZE, 3, kernel edge length; N = KERNEL_SIZE*KERNEL_SIZE+1 words per kernel.
- DATA_WIDTH, 16, width of each weight/bias word (signed fixed-point, opaque to this block).
- NUM_KERNELS, 4, number of kernels stored in weight memory.
- ADDR_WIDTH, 8, weight memory address width; must satisfy NUM_KERNELS*N <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_req  in  1  request to load a kernel; accepted only when load_busy=0.
- load_kernel_idx  in  $clog2(NUM_KERNELS) (min 1)  kernel to load, sampled with load_req.
- load_busy  out  1  high in READ and READY.
- load_done  out  1  one-cycle pulse when the shadow bank becomes full.
- load_err  out  1  one-cycle pulse when a request with an out-of-range index is rejected.
- swap  in  1  engine frame boundary; promotes shadow to active when the shadow is full.
- mem_rd_en  out  1  weight memory read enable.
- mem_addr  out  ADDR_WIDTH  weight memory address.
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- weights_out  out  DATA_WIDTH*KERNEL_SIZE²  active weights, packed.
- bias_out  out  DATA_WIDTH  active bias.
- weights_valid  out  1  active set holds a loaded kernel.

Behaviour:
- Memory layout:
  - Kernel k base address = k*N.
  - Words base+0 .. base+N-2 are weights 0..KERNEL_SIZE²-1 in row-major order.
  - Word base+N-1 is the bias.
- Packing: weight j occupies weights_out[(K²-j)*DW-1 : (K²-1-j)*DW], so weight 0 sits in the MSB slot and weight K²-1 in bits [DW-1:0].
- Reset (async, rst_n=0): state IDLE; all shadow and active registers 0; weights_out=0, bias_out=0, weights_valid=0, load_busy=0, load_done=0, load_err=0, mem_rd_en=0, mem_addr=0.
- Reset mid-load or in READY discards the shadow bank. Memory reads stop immediately.
- FSM states: IDLE, READ, READY.
- IDLE:
  - load_req=1 with idx < NUM_KERNELS: latch base, go to READ at the next edge.
  - load_req=1 with idx >= NUM_KERNELS: load_err pulses the next cycle; stay in IDLE.
  - swap in IDLE is ignored.
- READ:
  - Issue counter i runs 0..N-1. mem_rd_en=1 and mem_addr=base+i for exactly N consecutive cycles.
  - Capture counter trails by 1 cycle and writes mem_rd_data into shadow slot i-1. Slot N-1 is the bias.
  - After the bias is captured: go to READY, and load_done pulses in the first READY cycle.
  - If the request is sampled in cycle T: reads occur in cycles T+1..T+N, load_done is high in cycle T+N+2.
  - swap during READ is ignored and leaves the active set unchanged.
  - load_req during READ is ignored.
- READY:
  - On swap=1, the shadow set is copied to active at the next edge and weights_valid=1 from that edge on. The shadow is cleared logically; return to IDLE.
  - load_req during READY is ignored, including when it coincides with swap. A new load may be requested from IDLE, one cycle later.
- Active outputs change only on a promotion edge (or reset); they are glitch-free registered outputs.
- mem_rd_en=0 and mem_addr holds its last value outside READ.

Test Plan:
- Reset/default: hold rst_n=0, then release -> all outputs 0, load_busy=0, and no mem_rd_en for 20 idle cycles.
- Basic load:
  - Setup: K=3, NUM_KERNELS=4, memory word at address a = 16'h0100+a.
  - Stimulus: load_req with idx=2 in cycle T.
  - Response: mem_addr 20..29 in cycles T+1..T+10 and load_done in T+12.
  - After swap: weights_out[143:128]=16'h0114, weights_out[15:0]=16'h011C, bias_out=16'h011D, weights_valid=1.
- Double buffering: with kernel 0 active, load kernel 3 -> weights_out is unchanged through READY. The swap edge changes the MSB slot to 16'h011E and bias_out to 16'h0127.
- Illegal and ignored inputs:
  - load_req with idx=4 (width widened to allow 4) -> load_err pulse, no reads.
  - swap in IDLE -> weights_valid remains 0.
  - load_req during READ -> read count stays exactly 10.
- Simultaneous events: swap and load_req in the same READY cycle -> promotion occurs and the request is dropped (no mem_rd_en the next cycle). A load_req one cycle later is accepted.
- Reset mid-operation: assert rst_n=0 at the 5th read cycle -> mem_rd_en drops immediately, the active set clears, and a subsequent full load/swap produces correct values.
